mem_port_arbiter: RTL and testbench

- Shares the CPU's single 32-bit memory port between two requesters: instruction fetch (port 0, read-only) and load/store (port 1, read/write).
- Drives the select line of the address/data 2:1 multiplexers in front of memory.
- Sequences each transaction through a request/ready handshake with memory, with a timeout.
- Returns the read data and a completion pulse to the granted requester.

---
 rtl/mem_port_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter for the single memory port; grant->mem_req 1 cycle, min 3 cycles/transaction.
// Backpressure: requesters hold req until ack; memory stalls via mem_rdy, bounded by TIMEOUT (0 = wait forever).
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT = 255,
    parameter logic        RR_INIT = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic [31:0] addr0,
    input  logic        req1,
    input  logic        we1,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata1,
    input  logic        mem_rdy,
    input  logic [31:0] mem_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        sel,
    output logic        ack0,
    output logic        ack1,
    output logic        err,
    output logic [31:0] rdata,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_t      state_q;
    logic        mem_req_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic        sel_q;
    logic        ack0_q;
    logic        ack1_q;
    logic        err_q;
    logic [31:0] rdata_q;
    logic        busy_q;
    logic        last_grant_q;
    logic [15:0] cnt_q;
    logic        gnt_d;

    // On a tie the port that did not win last time gets the grant.
    always_comb begin
        gnt_d = req1;
        if (req0 && req1) begin
            gnt_d = ~last_grant_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            sel_q        <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            err_q        <= 1'b0;
            rdata_q      <= '0;
            busy_q       <= 1'b0;
            last_grant_q <= RR_INIT;
            cnt_q        <= '0;
        end else begin
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req0 || req1) begin
                        state_q      <= BUSY;
                        busy_q       <= 1'b1;
                        mem_req_q    <= 1'b1;
                        sel_q        <= gnt_d;
                        mem_addr_q   <= gnt_d ? addr1 : addr0;
                        mem_we_q     <= gnt_d & we1;
                        mem_wdata_q  <= gnt_d ? wdata1 : 32'd0;
                        last_grant_q <= gnt_d;
                        cnt_q        <= '0;
                    end
                end
                BUSY: begin
                    if (mem_rdy) begin
                        state_q   <= ACK;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        ack0_q    <= ~sel_q;
                        ack1_q    <= sel_q;
                        if (!mem_we_q) begin
                            rdata_q <= mem_rdata;
                        end
                    end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
                        state_q   <= ACK;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        ack0_q    <= ~sel_q;
                        ack1_q    <= sel_q;
                        err_q     <= 1'b1;
                        rdata_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                ACK: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign sel       = sel_q;
    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter, built with TIMEOUT=4 so the timeout paths are reachable quickly.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0;
    logic [31:0] addr0;
    logic        req1;
    logic        we1;
    logic [31:0] addr1;
    logic [31:0] wdata1;
    logic        mem_rdy;
    logic [31:0] mem_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        sel;
    logic        ack0;
    logic        ack1;
    logic        err;
    logic [31:0] rdata;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

    mem_port_arbiter #(.TIMEOUT(4), .RR_INIT(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .addr0(addr0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .mem_rdy(mem_rdy), .mem_rdata(mem_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .sel(sel), .ack0(ack0), .ack1(ack1), .err(err), .rdata(rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; stimulus and checks happen 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check_vec({tag, "_ctl"}, {22'd0, mem_req, mem_we, sel, ack0, ack1, err, busy, 3'd0}, 32'd0);
        check_vec({tag, "_addr"}, mem_addr, 32'd0);
        check_vec({tag, "_wdata"}, mem_wdata, 32'd0);
        check_vec({tag, "_rdata"}, rdata, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req0 = 1'b0; addr0 = '0; req1 = 1'b0; we1 = 1'b0;
        addr1 = '0; wdata1 = '0; mem_rdy = 1'b0; mem_rdata = '0;
        do_reset();
        check_reset_vals("reset");

        // Fetch with two BUSY cycles before mem_rdy.
        req0 = 1'b1; addr0 = 32'h0000_0040;
        tick();
        check_vec("t1_busy1_req", {31'd0, mem_req}, 32'd1);
        check_vec("t1_sel", {31'd0, sel}, 32'd0);
        check_vec("t1_addr", mem_addr, 32'h40);
        check_vec("t1_busyflag", {31'd0, busy}, 32'd1);
        tick();
        check_vec("t1_busy2_req", {31'd0, mem_req}, 32'd1);
        check_vec("t1_busy2_noack", {30'd0, ack1, ack0}, 32'd0);
        mem_rdy = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        tick();
        check_vec("t1_ack", {29'd0, err, ack1, ack0}, 32'b001);
        check_vec("t1_rdata", rdata, 32'hDEAD_BEEF);
        check_vec("t1_req_off", {31'd0, mem_req}, 32'd0);
        req0 = 1'b0; mem_rdy = 1'b0;
        tick();
        check_vec("t1_idle", {29'd0, busy, ack1, ack0}, 32'd0);
        check_vec("t1_rdata_hold", rdata, 32'hDEAD_BEEF);

        // Both held, immediate mem_rdy: grants alternate 0,1,0,1 from reset.
        do_reset();
        req0 = 1'b1; req1 = 1'b1; we1 = 1'b0; addr0 = 32'h80; addr1 = 32'h200; mem_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic exp_sel;
            exp_sel = i[0];
            tick();
            check_vec($sformatf("rr%0d_sel", i), {31'd0, sel}, {31'd0, exp_sel});
            check_vec($sformatf("rr%0d_addr", i), mem_addr, exp_sel ? 32'h200 : 32'h80);
            mem_rdata = 32'hA000_0000 + i;
            tick();
            check_vec($sformatf("rr%0d_ack", i), {29'd0, err, ack1, ack0},
                      exp_sel ? 32'b010 : 32'b001);
            check_vec($sformatf("rr%0d_rdata", i), rdata, 32'hA000_0000 + i);
            tick();
            check_vec($sformatf("rr%0d_idle", i), {29'd0, busy, ack1, ack0}, 32'd0);
        end

        // Store on port 1: rdata must keep the last load value.
        req0 = 1'b0; req1 = 1'b1; we1 = 1'b1; addr1 = 32'h100; wdata1 = 32'h1234_5678; mem_rdy = 1'b0;
        tick();
        check_vec("st_ctl", {29'd0, mem_req, mem_we, sel}, 32'b111);
        check_vec("st_addr", mem_addr, 32'h100);
        check_vec("st_wdata", mem_wdata, 32'h1234_5678);
        mem_rdy = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        tick();
        check_vec("st_ack", {29'd0, err, ack1, ack0}, 32'b010);
        check_vec("st_we_off", {31'd0, mem_we}, 32'd0);
        check_vec("st_rdata_keep", rdata, 32'hA000_0003);
        req1 = 1'b0; we1 = 1'b0; mem_rdy = 1'b0;
        tick();

        // Timeout: four BUSY cycles without mem_rdy, then ack1 with err.
        req1 = 1'b1; addr1 = 32'h300;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_vec($sformatf("to_busy%0d", i), {28'd0, busy, mem_req, ack1, err}, 32'b1100);
        end
        tick();
        check_vec("to_ack", {29'd0, err, ack1, ack0}, 32'b110);
        check_vec("to_rdata", rdata, 32'd0);
        check_vec("to_req_off", {31'd0, mem_req}, 32'd0);
        req1 = 1'b0;
        tick();
        check_vec("to_idle", {29'd0, busy, err, ack1}, 32'd0);

        // mem_rdy on the cycle the timeout would fire wins.
        req0 = 1'b1; addr0 = 32'h500;
        tick(); tick(); tick(); tick();
        check_vec("rt_busy4", {30'd0, mem_req, ack0}, 32'b10);
        mem_rdy = 1'b1; mem_rdata = 32'hCAFE_F00D;
        tick();
        check_vec("rt_ack", {29'd0, err, ack1, ack0}, 32'b001);
        check_vec("rt_rdata", rdata, 32'hCAFE_F00D);
        req0 = 1'b0; mem_rdy = 1'b0;
        tick();

        // Reset in the second BUSY cycle aborts the transaction.
        req0 = 1'b1; addr0 = 32'h600;
        tick();
        tick();
        check_vec("ab_busy2", {31'd0, mem_req}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0; req0 = 1'b0; mem_rdy = 1'b1; mem_rdata = 32'h5555_AAAA;
        check_reset_vals("ab_rst");
        tick();
        check_reset_vals("ab_post");
        mem_rdy = 1'b0; req0 = 1'b1; req1 = 1'b1; addr0 = 32'h700; addr1 = 32'h704;
        tick();
        check_vec("ab_tie_sel", {31'd0, sel}, 32'd0);
        check_vec("ab_tie_addr", mem_addr, 32'h700);
        mem_rdy = 1'b1; mem_rdata = 32'h0BAD_F00D;
        tick();
        check_vec("ab_tie_ack", {29'd0, err, ack1, ack0}, 32'b001);
        req0 = 1'b0; req1 = 1'b0; mem_rdy = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
